// File: rtl/conv_stream_pkg.sv
// Shared state encoding and sizing helpers for the conv pixel streamer.
// Pure declarations; no timing or flow control of its own.
package conv_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        STREAM,
        PAD_BOT,
        NEXT_CH,
        DONE
    } stream_state_t;

    // Words per channel plane; the per-channel address stride.
    function automatic int plane_words(input int width, input int height);
        return width * height;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// 2-entry FIFO carrying {pad_top, pixel}; head is combinational from storage.
// Latency: a push is visible at the head the next cycle.
// Backpressure: caller bounds pushes by credit; push with pop on full is legal.
module stream_skid_fifo #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/conv_pixel_streamer.sv
// Streams a CxHxW frame channel-major with start/pad/next_channel sideband; STREAM_CHECKSUM_EN adds frame_checksum.
// Latency: first beat of a channel 2 cycles after STREAM entry, then 1 beat/cycle.
// Backpressure: ready=0 holds the head beat; reads limited by 2 credits.
module conv_pixel_streamer
    import conv_stream_pkg::*;
#(
    parameter int IN_CHANNELS  = 4,
    parameter int IMAGE_WIDTH  = 16,
    parameter int IMAGE_HEIGHT = 10,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = $clog2(IN_CHANNELS * IMAGE_WIDTH * IMAGE_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_go,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  ready,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  pad_top,
    output logic                  pad_bottom,
    output logic                  start,
`ifdef STREAM_CHECKSUM_EN
    output logic signed [DATA_WIDTH+$clog2(IN_CHANNELS*IMAGE_WIDTH*IMAGE_HEIGHT)-1:0] frame_checksum,
`endif
    output logic                  next_channel
);

    localparam int PLANE  = plane_words(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int COL_W  = cnt_width(IMAGE_WIDTH);
    localparam int ROW_W  = cnt_width(IMAGE_HEIGHT);
    localparam int CH_W   = cnt_width(IN_CHANNELS);
    localparam int BEAT_W = cnt_width(PLANE);

    stream_state_t     state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [CH_W-1:0]   ch;
    logic [CH_W-1:0]   out_ch;
    logic [BEAT_W-1:0] beat_cnt;
    logic [1:0]        credit;
    logic [1:0]        fifo_count;
    logic [DATA_WIDTH:0] fifo_head;
    logic              fetch_done;
    logic              rd_pend;
    logic              rd_top;
    logic              pop;
    logic              last_col;
    logic              last_row;
    logic              last_beat;

    assign last_col  = (col == COL_W'(IMAGE_WIDTH - 1));
    assign last_row  = (row == ROW_W'(IMAGE_HEIGHT - 1));
    assign last_beat = (beat_cnt == BEAT_W'(PLANE - 1));
    assign valid_out = (fifo_count != 2'd0);
    assign pop       = valid_out & ready;
    assign pixel_out = valid_out ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign pad_top   = valid_out & fifo_head[DATA_WIDTH];

    // A credit freed by this cycle's pop may be spent immediately, which is
    // what keeps the 2-deep buffer at one beat per cycle.
    assign mem_rd_en = (state == STREAM) && !fetch_done && ((credit != 2'd0) || pop);
    assign mem_addr  = ADDR_WIDTH'(int'(ch) * PLANE + int'(row) * IMAGE_WIDTH + int'(col));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            start        <= 1'b0;
            pad_bottom   <= 1'b0;
            next_channel <= 1'b0;
            frame_done   <= 1'b0;
            out_ch       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_ch <= '0;
                    if (frame_go) begin
                        state <= START;
                        start <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    start <= 1'b0;
                    state <= STREAM;
                end
                STREAM: begin
                    if (pop && last_beat) begin
                        state      <= PAD_BOT;
                        pad_bottom <= 1'b1;
                    end
                end
                PAD_BOT: begin
                    pad_bottom <= 1'b0;
                    if (out_ch == CH_W'(IN_CHANNELS - 1)) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end else begin
                        state        <= NEXT_CH;
                        next_channel <= 1'b1;
                    end
                end
                NEXT_CH: begin
                    next_channel <= 1'b0;
                    out_ch       <= out_ch + 1'b1;
                    state        <= STREAM;
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            ch         <= '0;
            fetch_done <= 1'b0;
            credit     <= 2'd2;
            rd_pend    <= 1'b0;
            rd_top     <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            rd_pend <= mem_rd_en;
            rd_top  <= mem_rd_en && (row == '0);
            credit  <= credit - {1'b0, mem_rd_en} + {1'b0, pop};
            if (state == START || state == NEXT_CH) begin
                fetch_done <= 1'b0;
            end
            if (state == START) begin
                col <= '0;
                row <= '0;
                ch  <= '0;
            end else if (mem_rd_en) begin
                if (last_col) begin
                    col <= '0;
                    if (last_row) begin
                        row        <= '0;
                        fetch_done <= 1'b1;
                        ch         <= (ch == CH_W'(IN_CHANNELS - 1)) ? '0 : ch + 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (pop) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    stream_skid_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_pend),
        .push_data({rd_top, mem_rd_data}),
        .pop      (pop),
        .pop_data (fifo_head),
        .count    (fifo_count)
    );

`ifdef STREAM_CHECKSUM_EN
    localparam int SUM_W = DATA_WIDTH + $clog2(IN_CHANNELS * IMAGE_WIDTH * IMAGE_HEIGHT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_checksum <= '0;
        end else if (state == IDLE && frame_go) begin
            frame_checksum <= '0;
        end else if (pop) begin
            frame_checksum <= frame_checksum +
                {{(SUM_W-DATA_WIDTH){fifo_head[DATA_WIDTH-1]}}, fifo_head[DATA_WIDTH-1:0]};
        end
    end
`endif

endmodule

// File: tb/tb_conv_pixel_streamer.sv
// Directed bench for conv_pixel_streamer (C=2, H=3, W=4, memory word = address)
// with an event scoreboard covering beats and sideband pulses.
module tb_conv_pixel_streamer;

    localparam int C  = 2;
    localparam int H  = 3;
    localparam int W  = 4;
    localparam int DW = 16;
    localparam int AW = $clog2(C * H * W);

    localparam int TOP    = 1 << 16;
    localparam int E_START = 1 << 20;
    localparam int E_PADB  = 2 << 20;
    localparam int E_NEXT  = 3 << 20;
    localparam int E_DONE  = 4 << 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_go;
    logic          busy;
    logic          frame_done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          ready;
    logic          valid_out;
    logic [DW-1:0] pixel_out;
    logic          pad_top;
    logic          pad_bottom;
    logic          start;
    logic          next_channel;
`ifdef STREAM_CHECKSUM_EN
    logic signed [DW+AW-1:0] frame_checksum;
`endif

    conv_pixel_streamer #(
        .IN_CHANNELS (C),
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_go    (frame_go),
        .busy        (busy),
        .frame_done  (frame_done),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .ready       (ready),
        .valid_out   (valid_out),
        .pixel_out   (pixel_out),
        .pad_top     (pad_top),
        .pad_bottom  (pad_bottom),
        .start       (start),
`ifdef STREAM_CHECKSUM_EN
        .frame_checksum(frame_checksum),
`endif
        .next_channel(next_channel)
    );

    always #5 clk = ~clk;

    // Synchronous-read frame memory whose word equals its address.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= DW'(mem_addr);
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sb[$];
    int outstanding = 0;
    int n_done = 0;
    int t_start = 0, t_b0 = 0, t_b11 = 0, t_padb = 0, t_done = 0;
    bit hold_pending = 0;
    logic [DW-1:0] prev_pix;
    logic prev_top;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic observe(input int code);
        int exp;
        exp = (sb.size() != 0) ? sb.pop_front() : -1;
        chk("event_order", code, exp);
    endtask

    task automatic push_frame();
        sb.push_back(E_START);
        for (int c = 0; c < C; c++) begin
            for (int i = 0; i < W * H; i++) sb.push_back(c * W * H + i + ((i < W) ? TOP : 0));
            sb.push_back(E_PADB);
            if (c < C - 1) sb.push_back(E_NEXT);
        end
        sb.push_back(E_DONE);
    endtask

    // Output monitor: scoreboard pops, sideband exclusivity, hold stability, credit bound.
    always @(negedge clk) begin
        if (!rst) begin
            outstanding  = 0;
            hold_pending = 0;
        end else begin
            chk("sideband_excl", (start | pad_bottom | next_channel) & valid_out, 0);
            if (hold_pending) begin
                chk("hold_valid", valid_out, 1);
                chk("hold_pixel", pixel_out, prev_pix);
                chk("hold_top", pad_top, prev_top);
            end
            hold_pending = valid_out && !ready;
            prev_pix = pixel_out;
            prev_top = pad_top;
            if (start) begin
                observe(E_START);
                t_start = cyc;
            end
            if (valid_out && ready) begin
                observe(int'(pixel_out) + (pad_top ? TOP : 0));
                if (pixel_out == 0) t_b0 = cyc;
                if (pixel_out == 11) t_b11 = cyc;
            end
            if (pad_bottom) begin
                observe(E_PADB);
                t_padb = cyc;
            end
            if (next_channel) begin
                observe(E_NEXT);
                chk("next_after_padb", cyc - t_padb, 1);
            end
            if (frame_done) begin
                observe(E_DONE);
                t_done = cyc;
                n_done++;
            end
            outstanding = outstanding + (mem_rd_en ? 1 : 0) - ((valid_out && ready) ? 1 : 0);
            chk("credit_bound", outstanding <= 2, 1);
        end
    end

    task automatic go();
        @(negedge clk) frame_go = 1'b1;
        @(negedge clk) frame_go = 1'b0;
    endtask

    task automatic wait_frame_end(input bit toggle);
        bit ended = 0;
        for (int i = 0; i < 600 && !ended; i++) begin
            @(posedge clk);
            #1;
            if (toggle) ready = ~ready;
            ended = !busy && (sb.size() == 0);
        end
        ready = 1'b1;
        chk("frame_end", ended, 1);
    endtask

    task automatic wait_beat(input int v);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = valid_out && ready && (pixel_out == DW'(v));
        end
        chk("wait_beat", seen, 1);
    endtask

    initial begin
        rst = 1'b0;
        frame_go = 1'b0;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_pixel", pixel_out, 0);
        chk("rst_pad_top", pad_top, 0);
        chk("rst_pad_bottom", pad_bottom, 0);
        chk("rst_start", start, 0);
        chk("rst_next", next_channel, 0);
        rst = 1'b1;
        @(negedge clk);

        // 1: full-rate frame
        push_frame();
        go();
        chk("start_pulse", start, 1);
        chk("busy_on_go", busy, 1);
        wait_frame_end(0);
        chk("first_beat_latency", t_b0 - t_start, 3);
        chk("row_back_to_back", t_b11 - t_b0, 11);
        chk("done_after_padb", t_done - t_padb, 1);
        chk("busy_after_done", busy, 0);

        // 2: ready toggling every cycle
        push_frame();
        go();
        wait_frame_end(1);

        // 3: long stall in row 1
        push_frame();
        go();
        wait_beat(5);
        @(posedge clk);
        #1 ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_outstanding", outstanding, 2);
        chk("stall_valid", valid_out, 1);
        chk("stall_pixel", pixel_out, 6);
        chk("stall_no_read", mem_rd_en, 0);
        @(posedge clk);
        #1 ready = 1'b1;
        wait_frame_end(0);

        // 4: reset during beat 7, then a fresh frame
        push_frame();
        go();
        wait_beat(7);
        #2 rst = 1'b0;
        #1;
        chk("abort_valid", valid_out, 0);
        chk("abort_pixel", pixel_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", mem_rd_en, 0);
        chk("abort_addr", mem_addr, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_frame();
        go();
        chk("restart_start", start, 1);
        chk("restart_addr", mem_addr, 0);
        wait_frame_end(0);

        // 5: frame_go while busy is ignored
        n_done = 0;
        push_frame();
        go();
        repeat (5) @(negedge clk);
        go();
        wait_beat(20);
        go();
        wait_frame_end(0);
        repeat (4) @(negedge clk);
        chk("single_done", n_done, 1);
        chk("idle_after_ignored", busy, 0);

`ifdef STREAM_CHECKSUM_EN
        chk("checksum_total", frame_checksum, 276);
        push_frame();
        go();
        chk("checksum_cleared", frame_checksum, 0);
        wait_frame_end(0);
        chk("checksum_again", frame_checksum, 276);
`endif

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_pixel_streamer.md
Name: conv_pixel_streamer

Overview:
- Frame-side transmitter for conv2d_top: reads a C×H×W image from a synchronous-read frame memory and streams it channel-major, row-major, one pixel per beat.
- Generates the control sideband conv2d_top consumes: start, pad_top, pad_bottom and next_channel.
- Sits between the frame buffer and the conv line-buffer/MAC input, with downstream backpressure.

Parameters:
IN_CHANNELS, 4, channels per frame
IMAGE_WIDTH, 16, pixels per row
IMAGE_HEIGHT, 10, rows per channel
DATA_WIDTH, 16, signed pixel width
ADDR_WIDTH, $clog2(IN_CHANNELS*IMAGE_WIDTH*IMAGE_HEIGHT), frame memory address width

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low (assert 0)
frame_go  in  1  one-cycle request to stream one frame; ignored unless idle
busy  out  1  high from accept of frame_go until frame_done
frame_done  out  1  one-cycle pulse after the last channel completes
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_WIDTH  address = ch*W*H + row*W + col
mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
ready  in  1  downstream can accept a beat
valid_out  out  1  pixel_out valid; beat transfers when valid_out & ready
pixel_out  out  DATA_WIDTH  signed pixel
pad_top  out  1  high with every beat of row 0 of each channel
pad_bottom  out  1  one-cycle pulse, valid_out=0, after last beat of last row of each channel
start  out  1  one-cycle pulse, valid_out=0, before the first beat of a frame
next_channel  out  1  one-cycle pulse the cycle after pad_bottom, channels 0..C-2 only

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, counters, credits and buffer cleared. An in-flight read is discarded. Reset mid-frame aborts the frame with no frame_done.
- FSM states: IDLE -> START on frame_go (1 cycle, start=1) -> STREAM -> PAD_BOT (1 cycle).
- PAD_BOT -> NEXT_CH (1 cycle, next_channel=1) -> STREAM when ch<C-1; else -> DONE (1 cycle, frame_done=1) -> IDLE.
- frame_go while busy: ignored.
- Fetch: address counters col/row/ch advance on each mem_rd_en. col wraps at W-1 into row, and row wraps at H-1 into ch.
- Reads for a channel stop after its last address. Fetch for the next channel begins only in NEXT_CH.
- Output buffer: 2-entry FIFO plus credit counter (2 credits). A read is issued only if credit>0; the credit is returned on a pop.
- Sustains 1 beat/cycle when ready is held high. First beat of a channel appears 2 cycles after STREAM entry.
- Backpressure: while valid_out=1 and ready=0, pixel_out, pad_top and valid_out hold stable. No read is issued beyond credit.
- pad_top is a property of the beat: it travels with the data through the FIFO.
- Output order:
  - STREAM exits to PAD_BOT only when all W*H beats of the channel have transferred.
  - pad_bottom and next_channel are asserted regardless of ready.
  - start, pad_bottom and next_channel are never simultaneous with valid_out.
- Row/channel boundary beats are otherwise back-to-back; there is no bubble between rows.
- Simultaneous push and pop on a full FIFO is legal. The FIFO never overflows, since credits bound it at 2.

Optional Feature:
- Macro: STREAM_CHECKSUM_EN
- Defined: adds output frame_checksum [DATA_WIDTH+$clog2(C*H*W)-1:0], the signed running sum of transferred pixels. It clears on start and holds after frame_done until the next start; it is 0 on reset.
- Undefined: port and adder absent; all other behaviour identical.

Decomposition:
- Package conv_stream_pkg: FSM state enum (IDLE, START, STREAM, PAD_BOT, NEXT_CH, DONE) and the address-compute localparam for W*H.
- One sub-module: stream_skid_fifo (2-entry, DATA_WIDTH+1 bits carrying pixel and pad_top flag, push/pop/count).

Test Plan (C=2, H=3, W=4, memory word = address):
1. frame_go with ready=1:
   - start at cycle 1.
   - 12 beats of values 0..11; pad_top only on 0..3.
   - pad_bottom, then next_channel.
   - Beats 12..23, pad_top on 12..15, then pad_bottom; no next_channel; frame_done one cycle later.
2. ready toggling 1/0 every cycle -> identical value sequence 0..23. Outputs are stable during ready=0; mem_rd_en is never issued with credit=0.
3. ready=0 for 10 cycles mid-row 1 -> exactly 2 reads are outstanding/buffered. Stream resumes with no loss or duplication at value 6.
4. rst=0 asserted during beat 7, released, then frame_go -> all outputs 0 immediately. The new frame restarts at address 0 with start pulse and no frame_done from the aborted frame.
5. frame_go pulsed while busy -> ignored; exactly one frame_done.
6. With STREAM_CHECKSUM_EN: frame of values 0..23 -> frame_checksum=276 after frame_done; next start clears it to 0.
